gate_unit_arbiter: RTL

//  Round-robin arbiter that shares one bitwise logic unit (AND/OR/XOR/NAND) between NUM_REQ requesters.

---
 rtl/gate_unit_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter in front of one shared AND/OR/XOR/NAND unit; the result is registered with the winner's id.
// Latency: the result appears with rsp_valid one cycle after the request transfer; back-to-back rate is 1 per cycle.
// Backpressure: while a result is held and rsp_ready is low, no grant is issued and the result and pointer stay frozen.
module gate_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*2-1:0]       req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
);

  localparam int IDW = $clog2(NUM_REQ);
  // One extra bit so rr_ptr + offset never overflows before the modulo fold.
  localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic             any_valid;
  logic             can_issue;
  logic             issue;
  logic [IDW-1:0]   win;
  logic [IDW:0]     probe_sum;
  logic [IDW-1:0]   probe_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] y_calc;

  // Rotating priority search: first valid requester starting at rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    probe_sum = '0;
    probe_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (probe_sum >= NUM_REQ_W) begin
        probe_sum = probe_sum - NUM_REQ_W;
      end
      probe_idx = probe_sum[IDW-1:0];
      if (!any_valid && req_valid[probe_idx]) begin
        any_valid = 1'b1;
        win       = probe_idx;
      end
    end
  end

  // A grant may go out when nothing is held, or when the held result leaves this cycle.
  always_comb begin
    can_issue = (state_q == S_IDLE) || ((state_q == S_HOLD) && rsp_ready);
    issue     = rst_n && can_issue && any_valid;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && (win == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Select the winner's operand pair and opcode out of the packed request buses.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = OP_AND;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel  = req_a[i*WIDTH +: WIDTH];
        b_sel  = req_b[i*WIDTH +: WIDTH];
        op_sel = req_op[i*2 +: 2];
      end
    end
  end

  // Shared bitwise gate datapath; no carries, result is exactly WIDTH bits.
  always_comb begin
    y_calc = '0;
    case (op_sel)
      OP_AND:  y_calc = a_sel & b_sel;
      OP_OR:   y_calc = a_sel | b_sel;
      OP_XOR:  y_calc = a_sel ^ b_sel;
      OP_NAND: y_calc = ~(a_sel & b_sel);
      default: y_calc = '0;
    endcase
  end

  // Next-state: capture on a grant, drain to IDLE when the result leaves with nothing waiting.
  always_comb begin
    state_d  = state_q;
    rsp_y_d  = rsp_y_q;
    rsp_id_d = rsp_id_q;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      state_d  = S_HOLD;
      rsp_y_d  = y_calc;
      rsp_id_d = win;
      rr_ptr_d = (win == LAST_ID) ? '0 : win + IDW'(1);
    end else if ((state_q == S_HOLD) && rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  // FSM and result registers; reset drops any held result and restarts priority at requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rsp_y_q  <= '0;
      rsp_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = (state_q == S_HOLD);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule
